pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage core. It produces the `stall[5:0]` vector that every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb) consumes. It also sequences two multi-cycle resources: the divider, through a start/ready handshake, and the data bus, through a req/ack handshake. Pipeline flushes are scheduled here, so a flush never breaks an outstanding bus transaction.

---
 rtl/pipe_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline sequencing controller for the five-stage core.
//
// Generates the stall vector consumed by the pc, if_id, id_ex, ex_mem and
// mem_wb registers. It also sequences the two multi-cycle resources: the
// divider (start/ready handshake) and the data bus (req/ack handshake).
// Flushes are scheduled here so that a flush never abandons a bus transfer.
//
// Parameters:
//   DIV_TIMEOUT  cycles allowed in DIV_WAIT before the divide is abandoned
//   CNT_W        width of the stall-cycle counter (perf build only)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   stallreq_id    load-use hazard from ID
//   stallreq_ex    generic multi-cycle hold from EX
//   div_start_req  EX holds a div/divu
//   div_ready      divider result valid
//   div_start      one-cycle start pulse to the divider       (registered)
//   div_cancel     one-cycle abort pulse to the divider       (registered)
//   div_timeout    sticky divider-timeout error flag          (registered)
//   mem_req        MEM stage needs the data bus
//   bus_ack        bus transfer complete
//   bus_req        bus request, held until ack                (registered)
//   flush_req      exception / branch-redirect flush request
//   flush          flush pulse to all pipeline registers      (registered)
//   stall[5:0]     bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
//                  (combinational from state and inputs)
//   stall_cycles   saturating count of cycles with stall[3]=1
//                  (only when PIPE_CTRL_PERF_EN is defined)
//
// Build option:
//   PIPE_CTRL_PERF_EN  adds the stall_cycles port and counter.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             div_start_req,
  input  logic             div_ready,
  output logic             div_start,
  output logic             div_cancel,
  output logic             div_timeout,
  input  logic             mem_req,
  input  logic             bus_ack,
  output logic             bus_req,
  input  logic             flush_req,
  output logic             flush,
  output logic [5:0]       stall
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  // Stall patterns: a stage stalled while the next one runs inserts a bubble.
  localparam logic [5:0] STALL_BUS  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  // The counter only has to reach DIV_TIMEOUT-1.
  localparam int              CW       = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CW-1:0]   DIV_LAST = CW'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DIV_WAIT = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t          state;
  logic [CW-1:0]   div_cnt;
  logic            flush_pend;
  logic            bus_hold;
  logic            div_hold;

  // -------------------------------------------------------------------------
  // Stall vector. The FSM terms are gated by rst so that a held mem_req or
  // div_start_req cannot stall the pipe while reset is asserted; the hazard
  // inputs from ID/EX still pass straight through.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    bus_hold = 1'b0;
    div_hold = 1'b0;
    stall    = STALL_NONE;
    if (rst) begin
      case (state)
        IDLE: begin
          bus_hold = mem_req;
          // A flush in the launch cycle kills the divide before it starts.
          div_hold = !mem_req && div_start_req && !flush_req;
        end
        MEM_WAIT: bus_hold = !bus_ack;
        DIV_WAIT: div_hold = !div_ready && !flush_req;
        default:  ;
      endcase
    end
    if (bus_hold)                      stall = STALL_BUS;
    else if (div_hold || stallreq_ex)  stall = STALL_EX;
    else if (stallreq_id)              stall = STALL_ID;
  end

  // -------------------------------------------------------------------------
  // Sequencing FSM with registered handshake outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      flush_pend  <= 1'b0;
      bus_req     <= 1'b0;
      div_start   <= 1'b0;
      div_cancel  <= 1'b0;
      flush       <= 1'b0;
      div_timeout <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      div_start  <= 1'b0;
      div_cancel <= 1'b0;
      flush      <= 1'b0;

      case (state)
        IDLE: begin
          if (flush_req) flush <= 1'b1;
          // Bus first; a pending divide is taken on a later IDLE cycle.
          if (mem_req) begin
            bus_req <= 1'b1;
            state   <= MEM_WAIT;
          end else if (div_start_req && !flush_req) begin
            div_start <= 1'b1;
            div_cnt   <= '0;
            state     <= DIV_WAIT;
          end
        end

        MEM_WAIT: begin
          // The transfer always completes; a flush waits for the ack and is
          // merged with one arriving in the ack cycle into a single pulse.
          if (bus_ack) begin
            bus_req    <= 1'b0;
            flush      <= flush_pend | flush_req;
            flush_pend <= 1'b0;
            state      <= IDLE;
          end else if (flush_req) begin
            flush_pend <= 1'b1;
          end
        end

        DIV_WAIT: begin
          div_cnt <= div_cnt + 1'b1;
          // Flush wins over a result in the same cycle: the divide belongs
          // to an instruction that is being discarded.
          if (flush_req) begin
            div_cancel <= 1'b1;
            flush      <= 1'b1;
            state      <= IDLE;
          end else if (div_ready) begin
            state <= IDLE;
          end else if (div_cnt == DIV_LAST) begin
            div_timeout <= 1'b1;
            div_cancel  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          bus_req    <= 1'b0;
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Cycles in which EX is held; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall[3] && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`else
  // CNT_W only sizes the perf counter; keep it referenced in this build.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
